// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a programmed number of signed products from the 32x32 pipelined
//   multiplier into a wide accumulator and returns the 64-bit result over a
//   valid/ready handshake.
//
//   Optional feature: define ACC_SAT_EN to clamp the final sum to the signed
//   64-bit range and report clamping on sat. Without it, res is the low 64
//   bits of the accumulator (modular wrap) and sat is constant 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin a job (accepted only in IDLE)
//   len        number of products to sum, latched on accepted start
//   prod       signed product from the multiplier
//   prod_valid prod is valid this cycle
//   res        signed 64-bit result, registered
//   res_valid  res holds a completed result
//   res_ready  consumer accepts res
//   busy       high whenever the block is not IDLE
//   sat        result was clamped (ACC_SAT_EN only)
//   drop       sticky: a prod_valid arrived outside RUN
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 72
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic [63:0]       res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              sat,
  output logic              drop
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc, acc_next, prod_ext;
  logic [LEN_W-1:0]   cnt, len_q;
  logic               last;
  logic [63:0]        res_d;
  logic               sat_q, sat_d;

  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_next = acc + prod_ext;
  assign last     = (cnt == len_q - LEN_W'(1));

`ifdef ACC_SAT_EN
  logic pos_ovf, neg_ovf;
  // Sum fits in 64 bits only when bits [ACC_W-1:63] are all equal.
  assign pos_ovf = ~acc_next[ACC_W-1] & (|acc_next[ACC_W-2:63]);
  assign neg_ovf =  acc_next[ACC_W-1] & ~(&acc_next[ACC_W-2:63]);

  always_comb begin
    res_d = acc_next[63:0];
    sat_d = 1'b0;
    if (pos_ovf) begin
      res_d = 64'h7FFF_FFFF_FFFF_FFFF;
      sat_d = 1'b1;
    end else if (neg_ovf) begin
      res_d = 64'h8000_0000_0000_0000;
      sat_d = 1'b1;
    end
  end
`else
  assign res_d = acc_next[63:0];
  assign sat_d = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
      RUN:     if (prod_valid && last) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      res   <= '0;
      sat_q <= 1'b0;
      drop  <= 1'b0;
    end else begin
      if (prod_valid && state_q != RUN) drop <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
            // A product arriving with the accepted start is itself a drop,
            // so the cleared flag immediately picks it up.
            drop  <= prod_valid;
            if (len == '0) begin
              res   <= '0;
              sat_q <= 1'b0;
            end
          end
        end
        RUN: begin
          if (prod_valid) begin
            acc <= acc_next;
            cnt <= cnt + LEN_W'(1);
            if (last) begin
              res   <= res_d;
              sat_q <= sat_d;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sat = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [63:0] prod;
  logic        prod_valid;
  logic [63:0] res;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        sat;
  logic        drop;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(64), .LEN_W(8), .ACC_W(72)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .res(res), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .sat(sat), .drop(drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  localparam logic [63:0] NEG20   = 64'hFFFF_FFFF_FFFF_FFEC;
  localparam logic [63:0] MAXPOS  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINNEG  = 64'h8000_0000_0000_0000;

  logic [63:0] gap_prods [4];

  initial begin
    gap_prods[0] = 64'd10;
    gap_prods[1] = 64'hFFFF_FFFF_FFFF_FFFD; // -3
    gap_prods[2] = 64'd7;
    gap_prods[3] = 64'd100;

    rst = 1'b1; start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_res", res, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sat", {63'd0, sat}, 64'd0);
    chk("rst_drop", {63'd0, drop}, 64'd0);

    // 1: three consecutive -20 products
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    chk("t1_busy", {63'd0, busy}, 64'd1);
    prod = NEG20; prod_valid = 1'b1;
    tick(); tick();
    chk("t1_not_yet_valid", {63'd0, res_valid}, 64'd0);
    tick();
    prod_valid = 1'b0;
    chk("t1_res_valid", {63'd0, res_valid}, 64'd1);
    chk("t1_res", res, 64'hFFFF_FFFF_FFFF_FFC4);
    handshake();
    chk("t1_idle_busy", {63'd0, busy}, 64'd0);
    chk("t1_idle_valid", {63'd0, res_valid}, 64'd0);

    // 2: products with two idle cycles between them
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick(); tick();
        chk("t2_gap_no_result", {63'd0, res_valid}, 64'd0);
      end
      prod = gap_prods[i]; prod_valid = 1'b1;
      tick();
      prod_valid = 1'b0;
    end
    chk("t2_res_valid", {63'd0, res_valid}, 64'd1);
    chk("t2_res", res, 64'd114);
    handshake();

    // 3: zero-length job
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    chk("t3_res_valid", {63'd0, res_valid}, 64'd1);
    chk("t3_res", res, 64'd0);
    handshake();
    chk("t3_idle", {63'd0, busy}, 64'd0);

    // 4: result held while consumer stalls; start/prod_valid ignored
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0; prod = 64'd5; prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); prod_valid = (i % 2 == 1); len = 8'd3; prod = 64'd99;
      tick();
      chk("t4_hold_valid", {63'd0, res_valid}, 64'd1);
      chk("t4_hold_res", res, 64'd5);
    end
    start = 1'b0; prod_valid = 1'b0;
    chk("t4_drop", {63'd0, drop}, 64'd1);
    // start coinciding with the handshake must be ignored
    start = 1'b1;
    handshake();
    start = 1'b0;
    chk("t4_idle_after_hs", {63'd0, busy}, 64'd0);
    chk("t4_drop_sticky", {63'd0, drop}, 64'd1);

    // 5: overflow positive, then overflow negative
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    chk("t5_drop_cleared", {63'd0, drop}, 64'd0);
    prod = MAXPOS; prod_valid = 1'b1;
    tick(); tick();
    prod_valid = 1'b0;
    chk("t5_pos_valid", {63'd0, res_valid}, 64'd1);
`ifdef ACC_SAT_EN
    chk("t5_pos_res", res, MAXPOS);
    chk("t5_pos_sat", {63'd0, sat}, 64'd1);
`else
    chk("t5_pos_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t5_pos_sat", {63'd0, sat}, 64'd0);
`endif
    handshake();
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    prod = MINNEG; prod_valid = 1'b1;
    tick(); tick();
    prod_valid = 1'b0;
`ifdef ACC_SAT_EN
    chk("t5_neg_res", res, MINNEG);
    chk("t5_neg_sat", {63'd0, sat}, 64'd1);
`else
    chk("t5_neg_res", res, 64'd0);
    chk("t5_neg_sat", {63'd0, sat}, 64'd0);
`endif
    handshake();

    // 6: reset mid-job, then a fresh job sees no residue
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    prod = 64'd1000; prod_valid = 1'b1;
    tick(); tick();
    prod_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_res_valid", {63'd0, res_valid}, 64'd0);
    chk("t6_res", res, 64'd0);
    chk("t6_drop", {63'd0, drop}, 64'd0);
    chk("t6_sat", {63'd0, sat}, 64'd0);
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0; prod = NEG20; prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    chk("t6_fresh_valid", {63'd0, res_valid}, 64'd1);
    chk("t6_fresh_res", res, NEG20);
    handshake();
    chk("t6_final_idle", {63'd0, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
